// File: rtl/adder_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder tree.
// ext() widens a narrow value to a fixed maximum width; callers truncate.
package adder_tree_pkg;

    localparam int BEAT_W    = 16;
    localparam int EXT_MAX_W = 128;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tree_w(input int in_w, input int n_in);
        return in_w + clog2(n_in);
    endfunction

    function automatic int out_w(input int in_w, input int n_in, input int acc_x);
        return tree_w(in_w, n_in) + acc_x;
    endfunction

    // Bits at or above w copy bit w-1 when signed, else read as zero.
    function automatic logic [EXT_MAX_W-1:0] ext(input logic [EXT_MAX_W-1:0] v,
                                                 input int w,
                                                 input logic is_signed);
        logic [EXT_MAX_W-1:0] r;
        for (int b = 0; b < EXT_MAX_W; b++) begin
            r[b] = (b < w) ? v[b] : (is_signed & v[w-1]);
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: N operands of W bits become N/2 sums of W+1 bits.
// Operands are extended by one bit first, so a level can never overflow.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N      = 2,
    parameter int W      = 8,
    parameter int SIGNED = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N*W-1:0]         data_i,
    output logic [(N/2)*(W+1)-1:0] data_o
);

    localparam int M = N / 2;

    logic [M*(W+1)-1:0] sum_d;
    logic [M*(W+1)-1:0] sum_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < M; i++) begin
            sum_d[i*(W+1) +: W+1] =
                (W+1)'(ext(EXT_MAX_W'(data_i[(2*i)*W +: W]), W, SIGNED != 0)) +
                (W+1)'(ext(EXT_MAX_W'(data_i[(2*i+1)*W +: W]), W, SIGNED != 0));
        end
    end

    // Data loads every cycle; qualification travels separately in the top level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign data_o = sum_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N_IN-operand adder tree followed by a multi-beat group accumulator.
// One result per group, L+1 cycles after the group's last beat enters.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int N_IN   = 32,
    parameter int IN_W   = 32,
    parameter int ACC_X  = 8,
    parameter int SIGNED = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic [N_IN*IN_W-1:0]                in_data,
    output logic                                out_valid,
    output logic [out_w(IN_W, N_IN, ACC_X)-1:0] out_sum,
    output logic                                out_ovf,
    output logic [BEAT_W-1:0]                   out_beats
);

    localparam int                L        = clog2(N_IN);
    localparam int                TREE_W   = tree_w(IN_W, N_IN);
    localparam int                OUT_W    = out_w(IN_W, N_IN, ACC_X);
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    genvar k;
    generate
        for (k = 0; k <= L; k++) begin : g_lvl
            logic [(N_IN >> k)*(IN_W + k)-1:0] data;
            if (k == 0) begin : g_in
                assign data = in_data;
            end else begin : g_red
                adder_tree_level #(
                    .N      (N_IN >> (k - 1)),
                    .W      (IN_W + k - 1),
                    .SIGNED (SIGNED)
                ) u_level (
                    .clk_i  (clk),
                    .rst_ni (reset),
                    .data_i (g_lvl[k-1].data),
                    .data_o (data)
                );
            end
        end
    endgenerate

    logic [TREE_W-1:0] tree_sum;
    assign tree_sum = g_lvl[L].data;

    // Beat qualification: in_valid is accepted every cycle (no ready); vld/lst
    // shift alongside the data levels and clear empties the whole chain.
    logic [L-1:0] vld_d, vld_q, lst_d, lst_q;

    always_comb begin
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = in_valid & ~clear;
        lst_d[0] = in_last;
        for (int i = 1; i < L; i++) begin
            vld_d[i] = vld_q[i-1] & ~clear;
            lst_d[i] = lst_q[i-1];
        end
    end

    logic [OUT_W-1:0]  acc_d, acc_q, sum_ext, acc_base, acc_new;
    logic              ovf_d, ovf_q, ovf_new, ovf_now, carry;
    logic [BEAT_W-1:0] beats_d, beats_q, beats_new;
    logic              first_d, first_q;
    logic              out_valid_d, out_valid_q;
    logic [OUT_W-1:0]  out_sum_d, out_sum_q;
    logic              out_ovf_d, out_ovf_q;
    logic [BEAT_W-1:0] out_beats_d, out_beats_q;

    always_comb begin
        sum_ext          = OUT_W'(ext(EXT_MAX_W'(tree_sum), TREE_W, SIGNED != 0));
        acc_base         = first_q ? '0 : acc_q;
        {carry, acc_new} = {1'b0, acc_base} + {1'b0, sum_ext};
        if (SIGNED != 0) begin
            ovf_now = (acc_base[OUT_W-1] == sum_ext[OUT_W-1]) &&
                      (acc_new[OUT_W-1] != acc_base[OUT_W-1]);
        end else begin
            ovf_now = carry;
        end
        ovf_new   = (first_q ? 1'b0 : ovf_q) | ovf_now;
        beats_new = first_q ? BEAT_W'(1) :
                    ((beats_q == BEAT_MAX) ? beats_q : beats_q + 1'b1);

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        beats_d     = beats_q;
        first_d     = first_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_beats_d = out_beats_q;

        if (clear) begin
            first_d = 1'b1;
        end else if (vld_q[L-1]) begin
            acc_d   = acc_new;
            ovf_d   = ovf_new;
            beats_d = beats_new;
            first_d = lst_q[L-1];
            if (lst_q[L-1]) begin
                out_valid_d = 1'b1;
                out_sum_d   = acc_new;
                out_ovf_d   = ovf_new;
                out_beats_d = beats_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            beats_q     <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            beats_q     <= beats_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Three 8x8-bit adder trees (unsigned, signed, unsigned without headroom) share
// one stimulus stream and are scored against a delayed arithmetic group model.
module tb_adder_tree_pipe;

    localparam int N = 8;
    localparam int W = 8;
    localparam int L = 3;
    localparam bit SGN_CFG [3] = '{1'b0, 1'b1, 1'b0};
    localparam int OW_CFG  [3] = '{19, 19, 11};

    typedef struct packed {
        logic [31:0] cyc;
        logic [18:0] sum;
        logic        ovf;
        logic [15:0] beats;
    } res_t;

    typedef struct {
        int          e;
        logic [63:0] data;
        logic        last;
    } beat_t;

    // clock / reset
    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic clear    = 1'b0;
    logic in_valid = 1'b0;
    logic in_last  = 1'b0;
    logic [63:0] in_data = '0;

    always #5 clk = ~clk;

    logic        ov_u, oo_u, ov_s, oo_s, ov_o, oo_o;
    logic [18:0] os_u, os_s;
    logic [10:0] os_o;
    logic [15:0] ob_u, ob_s, ob_o;

    adder_tree_pipe #(.N_IN(N), .IN_W(W), .ACC_X(8), .SIGNED(0)) dut_u (
        .clk(clk), .reset(rst_n), .clear(clear), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .out_valid(ov_u), .out_sum(os_u), .out_ovf(oo_u), .out_beats(ob_u));

    adder_tree_pipe #(.N_IN(N), .IN_W(W), .ACC_X(8), .SIGNED(1)) dut_s (
        .clk(clk), .reset(rst_n), .clear(clear), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .out_valid(ov_s), .out_sum(os_s), .out_ovf(oo_s), .out_beats(ob_s));

    adder_tree_pipe #(.N_IN(N), .IN_W(W), .ACC_X(0), .SIGNED(0)) dut_o (
        .clk(clk), .reset(rst_n), .clear(clear), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .out_valid(ov_o), .out_sum(os_o), .out_ovf(oo_o), .out_beats(ob_o));

    // scoreboard and reference model state
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    beat_t  inflight[$];
    res_t   exp_q[3][$];
    res_t   obs_q[3][$];
    longint run[3];
    int     cnt[3];
    bit     movf[3];

    always @(negedge clk) begin
        if (ov_u) obs_q[0].push_back(res_t'{cyc, os_u, oo_u, ob_u});
        if (ov_s) obs_q[1].push_back(res_t'{cyc, os_s, oo_s, ob_s});
        if (ov_o) obs_q[2].push_back(res_t'{cyc, 19'(os_o), oo_o, ob_o});
    end

    function automatic logic [36:0] now_out(input int d);
        case (d)
            0:       return {ov_u, oo_u, ob_u, os_u};
            1:       return {ov_s, oo_s, ob_s, os_s};
            default: return {ov_o, oo_o, ob_o, 8'd0, os_o};
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            run[d]  = 0;
            cnt[d]  = 0;
            movf[d] = 1'b0;
        end
    endtask

    // Group model: exact integer sum, range check on every prefix, wrap on output.
    task automatic model_beat(input logic [63:0] data, input logic last);
        longint s, lo, hi;
        byte    sb;
        res_t   r;
        for (int d = 0; d < 3; d++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                sb = byte'(data[i*W +: W]);
                s += SGN_CFG[d] ? longint'(sb) : longint'(data[i*W +: W]);
            end
            run[d] += s;
            cnt[d]++;
            lo = SGN_CFG[d] ? -(longint'(1) <<< (OW_CFG[d] - 1)) : 0;
            hi = SGN_CFG[d] ? (longint'(1) <<< (OW_CFG[d] - 1)) : (longint'(1) <<< OW_CFG[d]);
            if (run[d] < lo || run[d] >= hi) movf[d] = 1'b1;
            if (last) begin
                r.cyc   = cyc;
                r.sum   = 19'(run[d] & ((longint'(1) <<< OW_CFG[d]) - 1));
                r.ovf   = movf[d];
                r.beats = (cnt[d] > 65535) ? 16'hFFFF : 16'(cnt[d]);
                exp_q[d].push_back(r);
                run[d]  = 0;
                cnt[d]  = 0;
                movf[d] = 1'b0;
            end
        end
    endtask

    // driver: one clock edge; a beat reaches the group model L edges after acceptance
    task automatic tick();
        beat_t b;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (clear) begin
                inflight.delete();
                model_reset();
            end else begin
                if (inflight.size() > 0 && inflight[0].e + L == cyc) begin
                    b = inflight.pop_front();
                    model_beat(b.data, b.last);
                end
                if (in_valid) inflight.push_back(beat_t'{cyc, in_data, in_last});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        logic [36:0] got;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            got = now_out(d);
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_assert dut%0d got %0h want 0", d, got);
            end
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        for (int d = 0; d < 3; d++) begin
            got = now_out(d);
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_release dut%0d got %0h want 0", d, got);
            end
        end
    endtask

    task automatic test_basic();
        int   e;
        res_t ro, re;
        in_data  = {8{8'hFF}};
        in_last  = 1'b1;
        in_valid = 1'b1;
        tick();
        e = cyc;
        idle(L + 3);
        checks++;
        if (obs_q[0].size() != 1) begin
            errors++;
            $display("FAIL basic_fixed got %0d results want 1", obs_q[0].size());
        end else if (obs_q[0][0] !== res_t'{32'(e + L), 19'd2040, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL basic_fixed got cyc=%0d sum=%0d ovf=%0b beats=%0d want cyc=%0d sum=2040 ovf=0 beats=1",
                     obs_q[0][0].cyc, obs_q[0][0].sum, obs_q[0][0].ovf, obs_q[0][0].beats, e + L);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL basic_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
                ro = obs_q[d].pop_front();
                re = exp_q[d].pop_front();
                checks++;
                if (ro !== re) begin
                    errors++;
                    $display("FAIL basic_result dut%0d got cyc=%0d sum=%0h ovf=%0b beats=%0d want cyc=%0d sum=%0h ovf=%0b beats=%0d",
                             d, ro.cyc, ro.sum, ro.ovf, ro.beats, re.cyc, re.sum, re.ovf, re.beats);
                end
            end
            obs_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    task automatic test_signed_group();
        res_t ro, re;
        in_data  = {8{8'h80}};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_last = (k == 2);
            tick();
        end
        idle(L + 3);
        checks++;
        if (obs_q[1].size() != 1) begin
            errors++;
            $display("FAIL signed_fixed got %0d results want 1", obs_q[1].size());
        end else if (obs_q[1][0].sum !== 19'(-3072) || obs_q[1][0].beats !== 16'd3 || obs_q[1][0].ovf !== 1'b0) begin
            errors++;
            $display("FAIL signed_fixed got sum=%0h beats=%0d ovf=%0b want sum=%0h beats=3 ovf=0",
                     obs_q[1][0].sum, obs_q[1][0].beats, obs_q[1][0].ovf, 19'(-3072));
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL signed_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
                ro = obs_q[d].pop_front();
                re = exp_q[d].pop_front();
                checks++;
                if (ro !== re) begin
                    errors++;
                    $display("FAIL signed_result dut%0d got cyc=%0d sum=%0h ovf=%0b beats=%0d want cyc=%0d sum=%0h ovf=%0b beats=%0d",
                             d, ro.cyc, ro.sum, ro.ovf, ro.beats, re.cyc, re.sum, re.ovf, re.beats);
                end
            end
            obs_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    task automatic test_overflow();
        res_t ro, re;
        in_valid = 1'b1;
        in_data  = {8{8'hFF}};
        in_last  = 1'b0;
        tick();
        in_last  = 1'b1;
        tick();
        in_data  = '0;
        tick();
        idle(L + 3);
        checks++;
        if (obs_q[2].size() != 2) begin
            errors++;
            $display("FAIL ovf_fixed got %0d results want 2", obs_q[2].size());
        end else if (obs_q[2][0].sum !== 19'd2032 || obs_q[2][0].ovf !== 1'b1 ||
                     obs_q[2][1].sum !== 19'd0 || obs_q[2][1].ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fixed got %0d/%0b then %0d/%0b want 2032/1 then 0/0",
                     obs_q[2][0].sum, obs_q[2][0].ovf, obs_q[2][1].sum, obs_q[2][1].ovf);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL ovf_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
                ro = obs_q[d].pop_front();
                re = exp_q[d].pop_front();
                checks++;
                if (ro !== re) begin
                    errors++;
                    $display("FAIL ovf_result dut%0d got cyc=%0d sum=%0h ovf=%0b beats=%0d want cyc=%0d sum=%0h ovf=%0b beats=%0d",
                             d, ro.cyc, ro.sum, ro.ovf, ro.beats, re.cyc, re.sum, re.ovf, re.beats);
                end
            end
            obs_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    task automatic test_back_to_back();
        res_t ro, re;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(i + k);
            tick();
        end
        idle(L + 3);
        checks++;
        if (obs_q[0].size() != 20) begin
            errors++;
            $display("FAIL b2b_pulses got %0d results want 20", obs_q[0].size());
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL b2b_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
                ro = obs_q[d].pop_front();
                re = exp_q[d].pop_front();
                checks++;
                if (ro !== re) begin
                    errors++;
                    $display("FAIL b2b_result dut%0d got cyc=%0d sum=%0h ovf=%0b beats=%0d want cyc=%0d sum=%0h ovf=%0b beats=%0d",
                             d, ro.cyc, ro.sum, ro.ovf, ro.beats, re.cyc, re.sum, re.ovf, re.beats);
                end
            end
            obs_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    task automatic test_random();
        res_t ro, re;
        for (int k = 0; k < 80; k++) begin
            in_valid = ($urandom_range(0, 3) != 0) || (k == 79);
            in_last  = ($urandom_range(0, 3) == 0) || (k == 79);
            in_data  = {$urandom(), $urandom()};
            tick();
        end
        idle(L + 3);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL random_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
                ro = obs_q[d].pop_front();
                re = exp_q[d].pop_front();
                checks++;
                if (ro !== re) begin
                    errors++;
                    $display("FAIL random_result dut%0d got cyc=%0d sum=%0h ovf=%0b beats=%0d want cyc=%0d sum=%0h ovf=%0b beats=%0d",
                             d, ro.cyc, ro.sum, ro.ovf, ro.beats, re.cyc, re.sum, re.ovf, re.beats);
                end
            end
            obs_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    task automatic test_clear();
        res_t ro, re;
        in_data  = {8{8'h11}};
        in_valid = 1'b1;
        in_last  = 1'b0;
        repeat (3) tick();
        idle(1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = {8{8'h22}};
        tick();
        clear    = 1'b0;
        in_last  = 1'b0;
        in_data  = {8{8'h05}};
        tick();
        in_last  = 1'b1;
        tick();
        idle(L + 3);
        checks++;
        if (obs_q[0].size() != 1) begin
            errors++;
            $display("FAIL clear_fixed got %0d results want 1", obs_q[0].size());
        end else if (obs_q[0][0].beats !== 16'd2 || obs_q[0][0].sum !== 19'd80) begin
            errors++;
            $display("FAIL clear_fixed got beats=%0d sum=%0d want beats=2 sum=80",
                     obs_q[0][0].beats, obs_q[0][0].sum);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL clear_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
                ro = obs_q[d].pop_front();
                re = exp_q[d].pop_front();
                checks++;
                if (ro !== re) begin
                    errors++;
                    $display("FAIL clear_result dut%0d got cyc=%0d sum=%0h ovf=%0b beats=%0d want cyc=%0d sum=%0h ovf=%0b beats=%0d",
                             d, ro.cyc, ro.sum, ro.ovf, ro.beats, re.cyc, re.sum, re.ovf, re.beats);
                end
            end
            obs_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    task automatic test_reset_mid_group();
        logic [36:0] got;
        res_t        ro, re;
        in_data  = {8{8'h33}};
        in_valid = 1'b1;
        in_last  = 1'b0;
        repeat (4) tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            got = now_out(d);
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_mid dut%0d got %0h want 0", d, got);
            end
        end
        inflight.delete();
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        in_data  = {8{8'h01}};
        in_valid = 1'b1;
        in_last  = 1'b1;
        tick();
        idle(L + 3);
        checks++;
        if (obs_q[0].size() != 1) begin
            errors++;
            $display("FAIL reset_fresh got %0d results want 1", obs_q[0].size());
        end else if (obs_q[0][0].sum !== 19'd8 || obs_q[0][0].beats !== 16'd1) begin
            errors++;
            $display("FAIL reset_fresh got sum=%0d beats=%0d want sum=8 beats=1",
                     obs_q[0][0].sum, obs_q[0][0].beats);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_q[d].size() != exp_q[d].size()) begin
                errors++;
                $display("FAIL resetmid_count dut%0d got %0d want %0d", d, obs_q[d].size(), exp_q[d].size());
            end
            while (obs_q[d].size() > 0 && exp_q[d].size() > 0) begin
                ro = obs_q[d].pop_front();
                re = exp_q[d].pop_front();
                checks++;
                if (ro !== re) begin
                    errors++;
                    $display("FAIL resetmid_result dut%0d got cyc=%0d sum=%0h ovf=%0b beats=%0d want cyc=%0d sum=%0h ovf=%0b beats=%0d",
                             d, ro.cyc, ro.sum, ro.ovf, ro.beats, re.cyc, re.sum, re.ovf, re.beats);
                end
            end
            obs_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_signed_group();
        test_overflow();
        test_back_to_back();
        test_random();
        test_clear();
        test_reset_mid_group();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Parametrised, fully pipelined binary adder tree with valid/last tracking, signed or unsigned operands and a multi-beat accumulation stage. Each valid beat reduces N_IN operands to one sum through log2(N_IN) registered levels. The accumulator then sums consecutive beats until a beat marked last, and emits one result per group. It sits behind the multiplier array of the dot-product and proxy compute engines, in place of the fixed 32-input, 32-bit tree.

## Interface
- N_IN, 32: operand count; power of two, 2..256; L = log2(N_IN).
- IN_W, 32: operand width.
- ACC_X, 8: extra accumulator headroom bits.
- SIGNED, 0: 1 = two's-complement operands and sums, 0 = unsigned.
- Derived: TREE_W = IN_W+L; OUT_W = TREE_W+ACC_X.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of pipeline valids and accumulator group.
- in_valid  in  1  beat qualifier.
- in_last  in  1  beat closes the current accumulation group.
- in_data  in  N_IN*IN_W  operand i at [i*IN_W +: IN_W].
- out_valid  out  1  one-cycle pulse; result of a completed group.
- out_sum  out  OUT_W  group sum.
- out_ovf  out  1  group sum exceeded OUT_W range (sticky within group).
- out_beats  out  16  beats in the group, saturating at 16'hFFFF.

## Operation
- Level k (1..L) registers N_IN/2^k sums of width IN_W+k. Operands are sign- or zero-extended per SIGNED, so no tree level ever overflows.
- Valid and last travel in a shift chain beside the data. Data registers load every cycle regardless of valid; only valid/last gate downstream state.
- Accumulator stage, on a valid tree beat:
  - acc <= (first ? 0 : acc) + ext(tree_sum); beats <= (first ? 1 : beats+1) saturating.
  - Overflow is detected per SIGNED: unsigned carry-out, or signed same-sign inputs giving a different-sign result. ovf <= (first ? 0 : ovf) | overflow_now.
  - If the beat is last: out_valid=1; out_sum/out_ovf/out_beats take the new values; first<=1. Otherwise first<=0.
- acc wraps modulo 2^OUT_W on overflow. out_ovf reports the wrap; the value is never saturated.
- Outputs hold their last values when out_valid=0.
- in_last=1 on every beat gives a plain pipelined tree sum with out_beats=1.
- clear: all valid bits <= 0, first<=1, out_valid<=0. Beats in flight are dropped and the partial group is discarded. in_valid sampled in the same cycle as clear is also dropped. out_sum/out_ovf/out_beats hold.
- Reset (async assert): all registers, including every data level, go to 0; first=1. The pipeline is empty after deassertion. A mid-group reset discards the group.
- No backpressure: one beat per cycle is always accepted.

## Timing
- Latency from in_valid to the matching accumulator update or out_valid: L+1 cycles. N_IN=32 gives 6.
- Throughput: one beat per clock; one group per clock when every beat is last.
- Back-to-back groups need no bubble. The beat after a last starts a new group in the next cycle.
- clear takes effect at the next edge. The first beat accepted after clear produces output L+1 cycles later.
- Reset values: out_valid=0, out_sum=0, out_ovf=0, out_beats=0.

## Structure
- Package adder_tree_pkg holds:
  - clog2 and width helper functions (TREE_W, OUT_W);
  - a sign/zero-extension function parameterised by SIGNED;
  - the beat-counter width constant (16).
- Sub-module adder_tree_level: one registered reduction level (N/2 adders, input width W, output W+1), instantiated L times by a generate loop. The valid/last chain and the accumulator live in the top level.

## Test plan
- N_IN=8, IN_W=8, SIGNED=0, all operands 8'hFF, in_last=1 for one beat -> out_valid exactly 4 cycles later; out_sum=2040, out_ovf=0, out_beats=1.
- SIGNED=1, N_IN=8, all operands 8'h80 (-128), 3 consecutive beats with last on the 3rd -> one out_valid; out_sum=-3072, out_beats=3, no intermediate out_valid.
- SIGNED=0, IN_W=8, N_IN=8, ACC_X=0 (OUT_W=11), 2 beats of all-8'hFF -> out_sum=4080 mod 2048=2032, out_ovf=1; the following single-beat group of zeros -> out_sum=0, out_ovf=0.
- Continuous 20 beats with in_last on every beat, operands i+cycle -> 20 out_valid pulses on consecutive cycles, each matching the reference-model sum.
- Group in flight with clear asserted for one cycle mid-pipeline -> no out_valid for the dropped beats; the next group's out_beats counts only post-clear beats.
- Reset asserted asynchronously (between edges) mid-group -> out_valid, out_sum, out_ovf and out_beats read 0 immediately; after release, a fresh single-beat group of all ones (N_IN=8) gives out_sum=8.
